change_dispenser: RTL and testbench

Change-return stage directly downstream of `retro_vending`. After a vend, it accepts the credit left over in cents over a valid/ready handshake. It then pays that amount out as quarters, dimes and nickels using a greedy largest-coin-first algorithm. Each coin is a timed eject pulse to the hopper solenoids, and the block keeps per-denomination stock counts.

---
 rtl/retro_vending_pkg.sv | 37 +++
 rtl/change_pulse_timer.sv | 29 ++
 rtl/change_dispenser.sv | 227 ++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retro_vending_pkg.sv
// Shared types and constants for the retro vending change path.
// Coin values, dispenser FSM states and coin select encoding.
package retro_vending_pkg;

  localparam int COIN_5_CENTS  = 5;
  localparam int COIN_10_CENTS = 10;
  localparam int COIN_25_CENTS = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } disp_state_e;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_NICKEL,
    COIN_DIME,
    COIN_QUARTER
  } coin_sel_e;

  // Solenoid pattern {25, 10, 5} for a selected coin.
  function automatic logic [2:0] coin_onehot(coin_sel_e c);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (c)
      COIN_QUARTER: oh = 3'b100;
      COIN_DIME:    oh = 3'b010;
      COIN_NICKEL:  oh = 3'b001;
      default:      oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/change_pulse_timer.sv
// Loadable down-counter timing eject pulses and inter-coin gaps.
// expired is high while the count sits at zero.
module change_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             count,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over counting; counting stops at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy quarter/dime/nickel change payout with timed solenoid pulses.
// Optional exact-change lamp output: CHANGE_DISP_EXACT_CHANGE_EN.
module change_dispenser
  import retro_vending_pkg::*;
#(
  parameter int CENTS_W      = 8,
  parameter int STOCK_W      = 6,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int INIT_Q       = 20,
  parameter int INIT_D       = 20,
  parameter int INIT_N       = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               change_valid,
  output logic               change_ready,
  input  logic [CENTS_W-1:0] change_amt,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_q,
  input  logic [STOCK_W-1:0] refill_d,
  input  logic [STOCK_W-1:0] refill_n,
  output logic               eject_25,
  output logic               eject_10,
  output logic               eject_5,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [CENTS_W-1:0] shortfall_amt,
  output logic [STOCK_W-1:0] stock_q,
  output logic [STOCK_W-1:0] stock_d,
  output logic [STOCK_W-1:0] stock_n
`ifdef CHANGE_DISP_EXACT_CHANGE_EN
  ,
  output logic               exact_change
`endif
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] PULSE_VAL =
    TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_VAL =
    TMR_W'(GAP_CYCLES - 1);

  localparam logic [CENTS_W-1:0] C25 =
    CENTS_W'(COIN_25_CENTS);
  localparam logic [CENTS_W-1:0] C10 =
    CENTS_W'(COIN_10_CENTS);
  localparam logic [CENTS_W-1:0] C5 =
    CENTS_W'(COIN_5_CENTS);

  disp_state_e        state_q;
  logic [CENTS_W-1:0] rem_q;
  logic [CENTS_W-1:0] rem_d;
  logic [STOCK_W-1:0] sq_q;
  logic [STOCK_W-1:0] sd_q;
  logic [STOCK_W-1:0] sn_q;
  logic [2:0]         eject_q;
  logic               busy_q;
  logic               done_q;
  logic               short_q;
  logic               rdy_q;
  logic [CENTS_W-1:0] shortfall_q;
  coin_sel_e          sel_d;

  logic             tmr_load;
  logic             tmr_count;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;

  // Greedy coin choice; the guards keep rem and stock from wrapping.
  always_comb begin
    sel_d = COIN_NONE;
    rem_d = rem_q;
    if (rem_q >= C25 && sq_q != '0) begin
      sel_d = COIN_QUARTER;
      rem_d = rem_q - C25;
    end else if (rem_q >= C10 && sd_q != '0) begin
      sel_d = COIN_DIME;
      rem_d = rem_q - C10;
    end else if (rem_q >= C5 && sn_q != '0) begin
      sel_d = COIN_NICKEL;
      rem_d = rem_q - C5;
    end
  end

  // One timer serves both the pulse and the gap phase.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    tmr_val   = GAP_VAL;
    unique case (state_q)
      ST_PICK: begin
        tmr_load = (sel_d != COIN_NONE);
        tmr_val  = PULSE_VAL;
      end
      ST_EJECT: begin
        tmr_load  = tmr_exp;
        tmr_count = 1'b1;
      end
      ST_GAP: begin
        tmr_count = 1'b1;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  change_pulse_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .count    (tmr_count),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Payout FSM with registered outputs and stock bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      sq_q        <= STOCK_W'(INIT_Q);
      sd_q        <= STOCK_W'(INIT_D);
      sn_q        <= STOCK_W'(INIT_N);
      eject_q     <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      rdy_q       <= 1'b1;
      shortfall_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (refill) begin
            sq_q <= refill_q;
            sd_q <= refill_d;
            sn_q <= refill_n;
          end else if (change_valid) begin
            rem_q       <= change_amt;
            shortfall_q <= '0;
            busy_q      <= 1'b1;
            rdy_q       <= 1'b0;
            state_q     <= ST_PICK;
          end
        end
        ST_PICK: begin
          if (sel_d == COIN_QUARTER) begin
            sq_q <= sq_q - 1'b1;
          end
          if (sel_d == COIN_DIME) begin
            sd_q <= sd_q - 1'b1;
          end
          if (sel_d == COIN_NICKEL) begin
            sn_q <= sn_q - 1'b1;
          end
          if (sel_d != COIN_NONE) begin
            rem_q   <= rem_d;
            eject_q <= coin_onehot(sel_d);
            state_q <= ST_EJECT;
          end else begin
            done_q      <= 1'b1;
            short_q     <= (rem_q != '0);
            shortfall_q <= rem_q;
            state_q     <= ST_DONE;
          end
        end
        ST_EJECT: begin
          if (tmr_exp) begin
            eject_q <= 3'b000;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_exp) begin
            state_q <= ST_PICK;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          short_q <= 1'b0;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          eject_q <= 3'b000;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A same-cycle refill blocks the handshake for that cycle.
  assign change_ready  = rdy_q & ~refill;
  assign eject_25      = eject_q[2];
  assign eject_10      = eject_q[1];
  assign eject_5       = eject_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign short         = short_q;
  assign shortfall_amt = shortfall_q;
  assign stock_q       = sq_q;
  assign stock_d       = sd_q;
  assign stock_n       = sn_q;

`ifdef CHANGE_DISP_EXACT_CHANGE_EN
  logic exact_q;

  // Lamp when nickels or dimes run too low to make change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exact_q <= 1'b0;
    end else begin
      exact_q <= (sn_q < STOCK_W'(2)) || (sd_q == '0);
    end
  end

  assign exact_change = exact_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser.
// Expected coins and results queued at accept, checked on output.
module tb_change_dispenser;

  localparam int CW  = 8;
  localparam int SW  = 6;
  localparam int P   = 4;
  localparam int G   = 4;
  localparam int PER = 1 + P + G;

  logic          clk = 1'b0;
  logic          reset;
  logic          change_valid;
  logic          change_ready;
  logic [CW-1:0] change_amt;
  logic          refill;
  logic [SW-1:0] refill_q;
  logic [SW-1:0] refill_d;
  logic [SW-1:0] refill_n;
  logic          eject_25;
  logic          eject_10;
  logic          eject_5;
  logic          busy;
  logic          done;
  logic          short;
  logic [CW-1:0] shortfall_amt;
  logic [SW-1:0] stock_q;
  logic [SW-1:0] stock_d;
  logic [SW-1:0] stock_n;
`ifdef CHANGE_DISP_EXACT_CHANGE_EN
  logic          exact_change;
`endif

  always #5 clk = ~clk;

  change_dispenser #(
    .CENTS_W      (CW),
    .STOCK_W      (SW),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .INIT_Q       (20),
    .INIT_D       (20),
    .INIT_N       (20)
  ) dut (
    .clk           (clk),
`ifdef CHANGE_DISP_EXACT_CHANGE_EN
    .exact_change  (exact_change),
`endif
    .reset         (reset),
    .change_valid  (change_valid),
    .change_ready  (change_ready),
    .change_amt    (change_amt),
    .refill        (refill),
    .refill_q      (refill_q),
    .refill_d      (refill_d),
    .refill_n      (refill_n),
    .eject_25      (eject_25),
    .eject_10      (eject_10),
    .eject_5       (eject_5),
    .busy          (busy),
    .done          (done),
    .short         (short),
    .shortfall_amt (shortfall_amt),
    .stock_q       (stock_q),
    .stock_d       (stock_d),
    .stock_n       (stock_n)
  );

  typedef struct {
    int         cyc;
    logic [2:0] coin;
  } ej_t;

  typedef struct {
    int         cyc;
    logic       shrt;
    logic [7:0] sf;
    logic [5:0] q;
    logic [5:0] d;
    logic [5:0] n;
  } res_t;

  ej_t  ej_q[$];
  res_t res_q[$];

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int done_cnt = 0;
  int width    = 0;
  bit abort    = 0;
  int mq, md, mn;

  logic [2:0] prev_ej = 3'b000;
  logic [2:0] ej;
  int         cyc;
  ej_t        e;
  res_t       r;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Output monitor: eject pulses and done results vs scoreboard.
  always @(negedge clk) begin
    ej  = {eject_25, eject_10, eject_5};
    cyc = edge_cnt - acc_edge + 1;
    if (reset) begin
      check("onehot0", 32'($onehot0(ej)), 32'd1);
    end
    if (ej != 3'b000 && prev_ej == 3'b000) begin
      if (ej_q.size() == 0) begin
        check("ej_unexpected", 32'(ej), 32'd0);
      end else begin
        e = ej_q.pop_front();
        check("ej_coin", 32'(ej), 32'(e.coin));
        check("ej_cycle", cyc, e.cyc);
      end
      width = 1;
    end else if (ej != 3'b000) begin
      check("ej_stable", 32'(ej), 32'(prev_ej));
      width++;
    end else if (prev_ej != 3'b000 && !abort) begin
      check("ej_width", width, P);
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (res_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        r = res_q.pop_front();
        check("done_cycle", cyc, r.cyc);
        check("short", 32'(short), 32'(r.shrt));
        check("shortfall", 32'(shortfall_amt), 32'(r.sf));
        check("stock_q", 32'(stock_q), 32'(r.q));
        check("stock_d", 32'(stock_d), 32'(r.d));
        check("stock_n", 32'(stock_n), 32'(r.n));
      end
    end
    prev_ej = ej;
  end

  // Greedy reference: queues coin events and the final result.
  task automatic model(input int amt);
    int rem = amt;
    int k = 0;
    bit go = 1;
    logic [2:0] c;
    while (go) begin
      c = 3'b000;
      if (rem >= 25 && mq > 0) begin
        c = 3'b100; rem -= 25; mq--;
      end else if (rem >= 10 && md > 0) begin
        c = 3'b010; rem -= 10; md--;
      end else if (rem >= 5 && mn > 0) begin
        c = 3'b001; rem -= 5; mn--;
      end else begin
        go = 0;
      end
      if (go) begin
        ej_q.push_back('{cyc: 2 + k * PER, coin: c});
        k++;
      end
    end
    res_q.push_back('{cyc: 2 + k * PER, shrt: (rem != 0),
                      sf: rem[7:0], q: mq[5:0],
                      d: md[5:0], n: mn[5:0]});
  endtask

  // Called at a negedge; leaves the request accepted.
  task automatic do_req(input int amt);
    int n = 0;
    change_valid = 1'b1;
    change_amt   = amt[CW-1:0];
    #1;
    while (!change_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("req_ready", 32'(change_ready), 32'd1);
    acc_edge = edge_cnt + 1;
    model(amt);
    @(negedge clk);
    change_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 400) begin
      @(negedge clk); n++;
    end
    check("done_seen", 32'(done_cnt != start), 32'd1);
    check("ej_left", ej_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_refill(input int q, input int d,
                           input int n);
    @(negedge clk);
    refill   = 1'b1;
    refill_q = q[SW-1:0];
    refill_d = d[SW-1:0];
    refill_n = n[SW-1:0];
    @(negedge clk);
    refill = 1'b0;
    mq = q; md = d; mn = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int dc;
    int n;
    reset        = 1'b0;
    change_valid = 1'b0;
    change_amt   = '0;
    refill       = 1'b0;
    refill_q     = '0;
    refill_d     = '0;
    refill_n     = '0;
    mq = 20; md = 20; mn = 20;
    repeat (3) @(negedge clk);
    check("rst_eject", 32'({eject_25, eject_10, eject_5}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_short", 32'(short), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sf", 32'(shortfall_amt), 32'd0);
    check("rst_sq", 32'(stock_q), 32'd20);
    check("rst_sd", 32'(stock_d), 32'd20);
    check("rst_sn", 32'(stock_n), 32'd20);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(change_ready), 32'd1);

    // 40 cents: Q, D, N, done in cycle 29
    do_req(40);
    @(negedge clk);
    check("busy_run", 32'(busy), 32'd1);
    wait_done();
    check("idle_busy", 32'(busy), 32'd0);

    // refill and request in the same cycle
    @(negedge clk);
    refill       = 1'b1;
    refill_q     = 6'd1;
    refill_d     = 6'd3;
    refill_n     = 6'd0;
    change_valid = 1'b1;
    change_amt   = 8'd30;
    #1;
    check("ready_refill", 32'(change_ready), 32'd0);
    @(negedge clk);
    refill = 1'b0;
    mq = 1; md = 3; mn = 0;
    #1;
    check("ready_after", 32'(change_ready), 32'd1);
    do_req(30);
    wait_done();
    check("sf_hold", 32'(shortfall_amt), 32'd5);

    // zero, odd residue and a multi-coin mix
    do_refill(20, 20, 20);
    @(negedge clk);
    do_req(0);
    wait_done();
    do_req(7);
    wait_done();
    do_req(65);
    wait_done();

    // reset during the second quarter of 50 cents
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = 8'd50;
    #1;
    check("ready_50", 32'(change_ready), 32'd1);
    acc_edge = edge_cnt + 1;
    ej_q.push_back('{cyc: 2, coin: 3'b100});
    ej_q.push_back('{cyc: 2 + PER, coin: 3'b100});
    @(negedge clk);
    change_valid = 1'b0;
    n = 0;
    while (edge_cnt - acc_edge + 1 < 3 + PER && n < 100) begin
      @(negedge clk); n++;
    end
    check("mid_ej25", 32'(eject_25), 32'd1);
    abort = 1;
    reset = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    check("rst_ej_drop",
          32'({eject_25, eject_10, eject_5}), 32'd0);
    check("rst_busy2", 32'(busy), 32'd0);
    check("rst_sq2", 32'(stock_q), 32'd20);
    check("rst_sd2", 32'(stock_d), 32'd20);
    check("rst_sn2", 32'(stock_n), 32'd20);
    check("rst_ej_left", ej_q.size(), 0);
    reset = 1'b1;
    mq = 20; md = 20; mn = 20;
    repeat (40) @(negedge clk);
    check("no_done", done_cnt - dc, 0);
    check("rst_ready2", 32'(change_ready), 32'd1);
    abort = 0;

    do_req(40);
    wait_done();

`ifdef CHANGE_DISP_EXACT_CHANGE_EN
    do_refill(20, 20, 1);
    repeat (2) @(negedge clk);
    check("exact_n1", 32'(exact_change), 32'd1);
    do_refill(20, 1, 5);
    repeat (2) @(negedge clk);
    check("exact_ok", 32'(exact_change), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
